// File: rtl/keystone_frame_ctrl.sv
// Frame-synchronous shadow of the homography coefficients and enable, raster
// tracker for the monitored input stream, and software-reset sequencer.
module keystone_frame_ctrl #(
  parameter int IMG_W      = 1920,
  parameter int IMG_H      = 1080,
  parameter int RST_CYCLES = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [255:0] cfg_h,
  input  logic         cfg_enable,
  input  logic         cfg_commit,
  input  logic         sw_reset,
  input  logic         mon_tvalid,
  input  logic         mon_tready,
  input  logic         mon_tuser,
  input  logic         mon_tlast,
  output logic [255:0] core_h,
  output logic         core_enable,
  output logic         core_sw_reset,
  output logic         commit_pending,
  output logic         commit_done,
  output logic [31:0]  frame_count,
  output logic         err_eol_early,
  output logic         err_eol_late,
  output logic         err_sof_missing
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(RST_CYCLES - 1);
  // Identity homography: H11 = H22 = 1.0 in the core's fixed-point format.
  localparam logic [255:0] H_IDENT = {96'd0, 32'h0100_0000, 96'd0, 32'h0100_0000};

  typedef enum logic [1:0] {RST_HOLD, IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          beat;
  logic          sof;
  logic          eol;
  logic          apply;

  assign beat          = mon_tvalid && mon_tready;
  assign sof           = beat && mon_tuser;
  assign eol           = (x == X_LAST) || mon_tlast;
  assign apply         = commit_pending && (state == IDLE) && !sof;
  assign core_sw_reset = (state == RST_HOLD);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= RST_HOLD;
      hold_cnt        <= '0;
      core_h          <= H_IDENT;
      core_enable     <= 1'b0;
      commit_pending  <= 1'b0;
      commit_done     <= 1'b0;
      frame_count     <= '0;
      x               <= '0;
      y               <= '0;
      err_eol_early   <= 1'b0;
      err_eol_late    <= 1'b0;
      err_sof_missing <= 1'b0;
    end else if (sw_reset) begin
      // A commit arriving alongside the reset request is dropped here.
      state           <= RST_HOLD;
      hold_cnt        <= '0;
      commit_pending  <= 1'b0;
      commit_done     <= 1'b0;
      x               <= '0;
      y               <= '0;
      err_eol_early   <= 1'b0;
      err_eol_late    <= 1'b0;
      err_sof_missing <= 1'b0;
    end else begin
      commit_done <= apply;
      if (apply) begin
        core_h         <= cfg_h;
        core_enable    <= cfg_enable;
        commit_pending <= 1'b0;
      end else if (cfg_commit && state != RST_HOLD) begin
        commit_pending <= 1'b1;
      end

      case (state)
        RST_HOLD: begin
          if (hold_cnt == C_LAST) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        IDLE, RUN: begin
          if (sof) begin
            x           <= XW'(1);
            y           <= '0;
            frame_count <= frame_count + 32'd1;
            state       <= RUN;
          end else if (beat) begin
            if (state == IDLE) begin
              err_sof_missing <= 1'b1;
            end else if (eol) begin
              // Line ends on tlast or on the last column, whichever comes first.
              if (mon_tlast && x != X_LAST) err_eol_early <= 1'b1;
              if (!mon_tlast)               err_eol_late  <= 1'b1;
              x <= '0;
              if (y == Y_LAST) begin
                y     <= '0;
                state <= IDLE;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: begin
          state    <= RST_HOLD;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keystone_frame_ctrl.sv
// Bench for keystone_frame_ctrl: directed frames on a reduced raster, checked
// every cycle against a behavioural model plus literal expectations.
module tb_keystone_frame_ctrl;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int RC = 16;
  localparam logic [255:0] H_ID = {96'd0, 32'h0100_0000, 96'd0, 32'h0100_0000};

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic         aresetn, cfg_enable, cfg_commit, sw_reset;
  logic         mon_tvalid, mon_tready, mon_tuser, mon_tlast;
  logic [255:0] cfg_h, core_h;
  logic         core_enable, core_sw_reset, commit_pending, commit_done;
  logic [31:0]  frame_count;
  logic         err_eol_early, err_eol_late, err_sof_missing;

  keystone_frame_ctrl #(.IMG_W(W), .IMG_H(H), .RST_CYCLES(RC)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_h(cfg_h), .cfg_enable(cfg_enable),
    .cfg_commit(cfg_commit), .sw_reset(sw_reset), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
    .core_h(core_h), .core_enable(core_enable), .core_sw_reset(core_sw_reset),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .frame_count(frame_count), .err_eol_early(err_eol_early),
    .err_eol_late(err_eol_late), .err_sof_missing(err_sof_missing));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           quiet = 0;     // clean cycles since the last reset request
  bit           m_run = 0;
  int           col = 0, row = 0;
  logic [255:0] m_h = '0;
  bit           m_en = 0, m_pend = 0, m_done = 0;
  bit           m_early = 0, m_late = 0, m_miss = 0;
  logic [31:0]  m_fc = '0;
  bit           model_ok = 0;

  always @(posedge aclk) begin
    bit hold, b, s;
    hold = (quiet < RC);
    b = mon_tvalid && mon_tready;
    s = b && mon_tuser;
    if (!aresetn || sw_reset) begin
      if (!aresetn) begin
        m_h = H_ID; m_en = 0; m_fc = '0; model_ok = 1;
      end
      quiet = 0; m_run = 0; col = 0; row = 0;
      m_pend = 0; m_done = 0; m_early = 0; m_late = 0; m_miss = 0;
    end else begin
      if (quiet < RC) quiet++;
      m_done = 0;
      if (!hold) begin
        if (m_pend && !m_run && !s) begin
          m_h = cfg_h; m_en = cfg_enable; m_pend = 0; m_done = 1;
        end else if (cfg_commit) begin
          m_pend = 1;
        end
        if (s) begin
          m_fc = m_fc + 1; m_run = 1; col = 1; row = 0;
        end else if (b && !m_run) begin
          m_miss = 1;
        end else if (b) begin
          if (mon_tlast || col == W - 1) begin
            if (col != W - 1) m_early = 1;
            else if (!mon_tlast) m_late = 1;
            col = 0;
            row++;
            if (row == H) begin row = 0; m_run = 0; end
          end else begin
            col++;
          end
        end
      end
    end
  end

  always @(negedge aclk) begin
    if (model_ok) begin
      chk("m_core_h", core_h, m_h);
      chk("m_core_enable", core_enable, m_en);
      chk("m_core_sw_reset", core_sw_reset, quiet < RC);
      chk("m_commit_pending", commit_pending, m_pend);
      chk("m_commit_done", commit_done, m_done);
      chk("m_frame_count", frame_count, m_fc);
      chk("m_err_eol_early", err_eol_early, m_early);
      chk("m_err_eol_late", err_eol_late, m_late);
      chk("m_err_sof_missing", err_sof_missing, m_miss);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic beat(input bit u, input bit l, input int gap, input bit c);
    repeat (gap) begin
      mon_tvalid = 1'($urandom_range(0, 1));
      mon_tready = !mon_tvalid;
      mon_tuser  = 1'b1;
      mon_tlast  = 1'b1;
      tick();
    end
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = u; mon_tlast = l; cfg_commit = c;
    tick();
    mon_tvalid = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic frame(input int gap_max, input int commit_row);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        beat(r == 0 && c == 0, c == W - 1, $urandom_range(0, gap_max), r == commit_row && c == 0);
  endtask

  task automatic count_hold(input string name);
    int n = 0;
    while (core_sw_reset && n < 100) begin
      n++;
      tick();
    end
    chk(name, n, RC);
  endtask

  function automatic logic [255:0] pat(input logic [7:0] tag);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = {tag, 24'(i * 7 + 1)};
    return p;
  endfunction

  logic [255:0] ha, hb, hc, hd;

  initial begin
    ha = pat(8'hA1); hb = pat(8'hB2); hc = pat(8'hC3); hd = pat(8'hD4);
    aresetn = 1'b0; cfg_h = '0; cfg_enable = 1'b0; cfg_commit = 1'b0; sw_reset = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;

    // Reset release
    count_hold("rst_pulse_len");
    chk("rst_h11", core_h[31:0], 32'h0100_0000);
    chk("rst_h22", core_h[159:128], 32'h0100_0000);
    chk("rst_h12", core_h[63:32], 32'h0);
    chk("rst_fc", frame_count, 0);
    chk("rst_en", core_enable, 0);

    // Commit while idle
    cfg_h = ha; cfg_enable = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("idle_pend", commit_pending, 1);
    chk("idle_en_before", core_enable, 0);
    tick();
    chk("idle_en", core_enable, 1);
    chk("idle_done", commit_done, 1);
    chk("idle_pend_clr", commit_pending, 0);
    chk("idle_h", core_h, ha);
    tick();
    chk("idle_done_pulse", commit_done, 0);

    // Commit mid-frame; coefficients sampled only when applied
    cfg_h = hc; cfg_enable = 1'b0;
    frame(2, H / 2);
    chk("mid_h_hold", core_h, ha);
    chk("mid_pend", commit_pending, 1);
    chk("mid_fc", frame_count, 1);
    cfg_h = hb;
    tick();
    chk("mid_h_apply", core_h, hb);
    chk("mid_done", commit_done, 1);
    chk("mid_en", core_enable, 0);

    // Early and late end-of-line
    beat(1, 0, 0, 0);
    for (int c = 1; c < 5; c++) beat(0, 0, 0, 0);
    beat(0, 1, 0, 0);
    chk("early_flag", err_eol_early, 1);
    chk("early_no_late", err_eol_late, 0);
    for (int c = 0; c < W; c++) beat(0, 0, 1, 0);
    chk("late_flag", err_eol_late, 1);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("swr_early_clr", err_eol_early, 0);
    chk("swr_late_clr", err_eol_late, 0);
    count_hold("swr_pulse_len");

    // Missing SOF while idle
    beat(0, 0, 0, 0);
    chk("miss_flag", err_sof_missing, 1);
    chk("miss_fc", frame_count, 2);
    sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    chk("miss_clr", err_sof_missing, 0);
    repeat (RC) tick();

    // SOF inside a running frame restarts it without a late error
    beat(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) beat(0, 0, 0, 0);
    beat(1, 0, 0, 0);
    for (int i = 1; i < W * H; i++) beat(0, (i % W) == W - 1, 0, 0);
    chk("restart_late", err_eol_late, 0);
    chk("restart_early", err_eol_early, 0);
    chk("restart_fc", frame_count, 4);

    // Commit coinciding with SOF defers to the next gap
    cfg_h = hd; cfg_enable = 1'b1;
    beat(1, 0, 0, 1);
    chk("sofc_pend", commit_pending, 1);
    chk("sofc_h_hold", core_h, hb);
    for (int i = 1; i < W * H; i++) beat(0, (i % W) == W - 1, 0, 0);
    chk("sofc_h_end", core_h, hb);
    tick();
    chk("sofc_h_apply", core_h, hd);
    chk("sofc_en", core_enable, 1);

    // Commit coinciding with sw_reset is dropped
    cfg_h = ha; cfg_enable = 1'b0; cfg_commit = 1'b1; sw_reset = 1'b1;
    tick();
    cfg_commit = 1'b0; sw_reset = 1'b0;
    chk("swc_pend", commit_pending, 0);
    repeat (RC) tick();
    chk("swc_out_of_hold", core_sw_reset, 0);
    repeat (2) tick();
    chk("swc_h_kept", core_h, hd);
    chk("swc_en_kept", core_enable, 1);

    // Two clean frames with handshake gaps
    frame(3, -1);
    frame(3, -1);
    chk("two_fc", frame_count, 7);
    chk("two_early", err_eol_early, 0);
    chk("two_late", err_eol_late, 0);
    chk("two_miss", err_sof_missing, 0);
    beat(0, 0, 0, 0);
    chk("two_idle", err_sof_missing, 1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keystone_frame_ctrl.md
KEYSTONE_FRAME_CTRL -- requirements
Module: keystone_frame_ctrl

Purpose: frame-synchronous configuration sequencer for the Keystone core. It shadows the homography coefficients and the enable bit, applies updates only between frames, tracks the raster position of the input stream, and sequences software reset.

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 - IMG_W, 1920, pixels per line.
 - IMG_H, 1080, lines per frame.
 - RST_CYCLES, 16, length of the core reset pulse.
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 cfg_h  in  256  staged coefficients: H11 [31:0], H12 [63:32], H13 [95:64], H21 [127:96], H22 [159:128], H23 [191:160], H31 [223:192], H32 [255:224].
REQ-005 cfg_enable  in  1  staged keystone enable.
REQ-006 cfg_commit  in  1  single-cycle request to apply cfg_h and cfg_enable.
REQ-007 sw_reset  in  1  software reset request, level-sensitive.
REQ-008 mon_tvalid, mon_tready, mon_tuser, mon_tlast  in  1 each  monitored input-stream handshake.
REQ-009 core_h  out  256  active coefficients to the core, same packing as cfg_h.
REQ-010 core_enable  out  1  active ENABLE_KEYSTONE.
REQ-011 core_sw_reset  out  1  SW_RESET to the core.
REQ-012 commit_pending  out  1  a commit is latched but not yet applied.
REQ-013 commit_done  out  1  one-cycle pulse when an update is applied.
REQ-014 frame_count  out  32  count of accepted SOF beats, wrapping.
REQ-015 err_eol_early, err_eol_late, err_sof_missing  out  1 each  sticky stream-error flags.

Function
REQ-016 A beat is any cycle with mon_tvalid && mon_tready; all stream tracking advances on beats only.
REQ-017 State machine states: RST_HOLD, IDLE, RUN.
 - RST_HOLD -> IDLE after RST_CYCLES consecutive cycles with sw_reset low.
 - IDLE -> RUN on an SOF beat (mon_tuser=1).
 - RUN -> IDLE on the beat ending line IMG_H-1.
 - Any state -> RST_HOLD when sw_reset=1.
REQ-018 core_sw_reset is 1 exactly while in RST_HOLD.
REQ-019 In RST_HOLD the block clears x, y, all error flags and commit_pending; core_h and core_enable hold their values.
REQ-020 The RST_HOLD counter restarts while sw_reset stays high.
REQ-021 SOF beat in any of IDLE or RUN:
 - x := 1, y := 0.
 - frame_count increments by 1 (modular 2^32).
 - State becomes RUN.
 - If the SOF beat arrives in RUN, the frame restarts and err_eol_late is not set for the truncated frame.
REQ-022 Non-SOF beat in RUN, x < IMG_W-1, tlast=0: x increments.
REQ-023 Non-SOF beat in RUN with tlast=1 and x != IMG_W-1: set err_eol_early, x := 0, y increments.
REQ-024 Non-SOF beat in RUN with x == IMG_W-1 and tlast=0: set err_eol_late, x := 0, y increments (resynchronise).
REQ-025 Non-SOF beat in RUN with x == IMG_W-1 and tlast=1: x := 0, y increments with no error.
REQ-026 When y would increment past IMG_H-1: y := 0 and the state becomes IDLE.
REQ-027 A non-SOF beat in IDLE sets err_sof_missing and leaves x, y and state unchanged.
REQ-028 cfg_commit=1 in IDLE or RUN sets commit_pending; a repeat commit while pending is absorbed.
REQ-029 cfg_h and cfg_enable are sampled when the update applies, not when cfg_commit is asserted.
REQ-030 An update applies on the first edge where commit_pending=1, the state is IDLE, and no SOF beat occurs in that cycle. On that edge:
 - core_h := cfg_h and core_enable := cfg_enable.
 - commit_pending clears.
 - commit_done pulses for one cycle.
REQ-031 If cfg_commit and an SOF beat occur in the same IDLE cycle, the update defers to the next inter-frame gap; core_h never changes while in RUN.
REQ-032 If cfg_commit and sw_reset occur in the same cycle, sw_reset wins and the commit is discarded.
REQ-033 Error flags clear only in RST_HOLD or on aresetn.

Reset
REQ-034 On aresetn=0:
 - State := RST_HOLD, counter := 0.
 - core_h := 0, except H11 = H22 = 32'h0100_0000 (identity).
 - core_enable := 0, core_sw_reset := 1.
 - commit_pending := 0, commit_done := 0, frame_count := 0, x := 0, y := 0.
 - All error flags := 0.
REQ-035 After aresetn returns high, the block leaves RST_HOLD after RST_CYCLES cycles.

Verification
REQ-036 Release aresetn -> core_sw_reset stays high for 16 cycles, then low; core_h[31:0] = 32'h0100_0000; frame_count = 0.
REQ-037 Commit in IDLE with cfg_enable=1 -> next edge: core_enable=1, commit_done is a single pulse, commit_pending=0.
REQ-038 Commit mid-frame (RUN, y=500) -> core_h unchanged until the beat ending line 1079; applied one cycle after entering IDLE.
REQ-039 Line with tlast on x=100 -> err_eol_early=1, y increments; a later line with no tlast at x=1919 -> err_eol_late=1.
REQ-040 Beat without tuser while IDLE -> err_sof_missing=1; sw_reset for 1 cycle -> all flags 0 and core_sw_reset high for 16 cycles.
REQ-041 Two full frames with ready/valid gaps -> frame_count = 2, no error flags, state IDLE after 2 x 2073600 beats.
